// File: rtl/comparador_sar_ctrl.sv
// Successive-approximation register controller. It samples the input, then tries each
// code bit MSB-first against the comparator and keeps the bits the comparator accepts.
module comparador_sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int                 IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]   IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [3:0]         CNT_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_TRIAL,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               sample_q, sample_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   dac_q, dac_d;
  logic [WIDTH-1:0]   bit_q;
  logic [WIDTH-1:0]   decided;

  assign bit_q   = WIDTH'(1) << idx_q;
  assign decided = cmp_i ? (work_q | bit_q) : work_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    work_d   = work_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SAMPLE;
          work_d  = '0;
          idx_d   = IDX_MSB;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE: begin
        cnt_d = '0;
        if (abort_i) begin
          state_d = ST_IDLE;
          work_d  = '0;
        end else begin
          state_d = ST_TRIAL;
        end
      end
      ST_TRIAL: begin
        // Abort wins over a bit decision landing on the same edge.
        if (abort_i) begin
          state_d = ST_IDLE;
          work_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          work_d = decided;
          cnt_d  = '0;
          if (idx_q == '0) begin
            state_d  = ST_DONE;
            result_d = decided;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave straight from flops.
    sample_d = (state_d == ST_SAMPLE);
    busy_d   = (state_d == ST_SAMPLE) || (state_d == ST_TRIAL);
    done_d   = (state_d == ST_DONE);
    dac_d    = (state_d == ST_TRIAL) ? (work_d | (WIDTH'(1) << idx_d)) : '0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dac_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dac_q    <= dac_d;
    end
  end

  assign sample_o   = sample_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign dac_code_o = dac_q;
  assign result_o   = result_q;

endmodule
